// File: rtl/mul_pkg.sv
// Shared constants for the repeated-addition multiplier: default widths and
// controller state encodings used by both controller and datapath benches.
package mul_pkg;

    localparam int MUL_W  = 16;
    localparam int MUL_PW = 32;

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } mul_state_e;

endpackage

// File: rtl/mul_result_buf.sv
// Result buffer: detects the rising edge of done, captures the accumulator
// and holds it under a valid/ready handshake (newest capture wins).
module mul_result_buf #(
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          done_i,
    input  logic [PW-1:0] p_i,
    input  logic          result_ready_i,
    output logic [PW-1:0] product_o,
    output logic          result_valid_o
);

    logic          done_q;
    logic [PW-1:0] product_q, product_d;
    logic          valid_q, valid_d;
    logic          capture;

    assign capture = done_i & ~done_q;

    // A capture in the same cycle as acceptance keeps valid high.
    always_comb begin
        product_d = product_q;
        valid_d   = valid_q;
        if (capture) begin
            product_d = p_i;
            valid_d   = 1'b1;
        end else if (result_ready_i) begin
            valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            product_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            done_q    <= done_i;
            product_q <= product_d;
            valid_q   <= valid_d;
        end
    end

    assign product_o      = product_q;
    assign result_valid_o = valid_q;

endmodule

// File: rtl/mul_datapath.sv
// Multiplier datapath: operand A, down-counter B, accumulator P and result buffer.
// Define MUL_DP_SAT_EN to saturate P on carry-out and report a sticky ovf flag.
module mul_datapath
    import mul_pkg::*;
#(
    parameter int W  = MUL_W,
    parameter int PW = MUL_PW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  data_in,
    input  logic          lda,
    input  logic          ldb,
    input  logic          ldp,
    input  logic          clrp,
    input  logic          decb,
    input  logic          done,
    output logic          zf,
    output logic [PW-1:0] product,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          ovf
);

    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [PW-1:0] p_q, p_d;

    assign zf = (b_q == '0);

    always_comb begin
        a_d = lda ? data_in : a_q;
    end

    // B stops at zero rather than wrapping.
    always_comb begin
        b_d = b_q;
        if (ldb)
            b_d = data_in;
        else if (decb && !zf)
            b_d = b_q - W'(1);
    end

`ifdef MUL_DP_SAT_EN
    localparam int PW1 = PW + 1;
    logic [PW:0] sum;
    logic        ovf_q, ovf_d;

    assign sum = {1'b0, p_q} + PW1'(a_q);

    always_comb begin
        p_d   = p_q;
        ovf_d = ovf_q;
        if (clrp) begin
            p_d   = '0;
            ovf_d = 1'b0;
        end else if (ldp && !zf) begin
            if (sum[PW]) begin
                p_d   = '1;
                ovf_d = 1'b1;
            end else begin
                p_d   = sum[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_q <= 1'b0;
        else
            ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    logic [PW-1:0] sum;

    assign sum = p_q + PW'(a_q);

    // Accumulate is suppressed at B == 0 so a zero multiplier yields zero.
    always_comb begin
        p_d = p_q;
        if (clrp)
            p_d = '0;
        else if (ldp && !zf)
            p_d = sum;
    end

    assign ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            p_q <= p_d;
        end
    end

    mul_result_buf #(.PW(PW)) u_result_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .done_i         (done),
        .p_i            (p_q),
        .result_ready_i (result_ready),
        .product_o      (product),
        .result_valid_o (result_valid)
    );

endmodule

// File: tb/tb_mul_datapath.sv
// Self-checking bench for mul_datapath: per-cycle behavioural model plus directed
// vectors with literal expectations; a narrow W=4/PW=4 instance covers overflow.
module tb_mul_datapath;
    import mul_pkg::*;

    localparam int W  = MUL_W;
    localparam int PW = MUL_PW;
`ifdef MUL_DP_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [W-1:0]  data_in;
    logic          lda, ldb, ldp, clrp, decb, done, result_ready;
    logic          zf, result_valid, ovf;
    logic [PW-1:0] product;

    mul_datapath #(.W(W), .PW(PW)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in),
        .lda(lda), .ldb(ldb), .ldp(ldp), .clrp(clrp), .decb(decb), .done(done),
        .zf(zf), .product(product), .result_valid(result_valid),
        .result_ready(result_ready), .ovf(ovf)
    );

    logic       s_rst_n, s_lda, s_ldb, s_ldp, s_clrp, s_decb, s_done, s_ready;
    logic [3:0] s_data, s_product;
    logic       s_zf, s_valid, s_ovf;

    mul_datapath #(.W(4), .PW(4)) dut_s (
        .clk(clk), .rst_n(s_rst_n), .data_in(s_data),
        .lda(s_lda), .ldb(s_ldb), .ldp(s_ldp), .clrp(s_clrp), .decb(s_decb), .done(s_done),
        .zf(s_zf), .product(s_product), .result_valid(s_valid),
        .result_ready(s_ready), .ovf(s_ovf)
    );

    int checks = 0;
    int errors = 0;

    longint m_a, m_b, m_p, m_prod;
    bit     m_valid, m_ovf, m_done_q;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: what each register must hold after a clock edge, from the
    // inputs seen at that edge, in plain integer arithmetic.
    task automatic model_step();
        longint lim;
        longint sum;
        longint n_a, n_b, n_p, n_prod;
        bit     n_valid, n_ovf, cap;
        lim = longint'(1) << PW;
        if (!rst_n) begin
            m_a = 0; m_b = 0; m_p = 0; m_prod = 0;
            m_valid = 0; m_ovf = 0; m_done_q = 0;
            return;
        end
        cap     = done && !m_done_q;
        n_prod  = cap ? m_p : m_prod;
        n_valid = cap ? 1'b1 : (result_ready ? 1'b0 : m_valid);
        n_a     = lda ? longint'(data_in) : m_a;
        if (ldb)                  n_b = longint'(data_in);
        else if (decb && m_b > 0) n_b = m_b - 1;
        else                      n_b = m_b;
        n_p   = m_p;
        n_ovf = m_ovf;
        if (clrp) begin
            n_p = 0; n_ovf = 0;
        end else if (ldp && m_b != 0) begin
            sum = m_p + m_a;
            if (sum < lim)  n_p = sum;
            else if (SAT) begin n_p = lim - 1; n_ovf = 1; end
            else            n_p = sum - lim;
        end
        m_a = n_a; m_b = n_b; m_p = n_p; m_prod = n_prod;
        m_valid = n_valid; m_ovf = n_ovf; m_done_q = done;
    endtask

    // One clock: model follows the edge, then every output and register is compared.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("zf", zf, (m_b == 0));
        chk("product", product, m_prod);
        chk("result_valid", result_valid, m_valid);
        chk("ovf", ovf, m_ovf);
        chk("reg_a", dut.a_q, m_a);
        chk("reg_b", dut.b_q, m_b);
        chk("reg_p", dut.p_q, m_p);
    endtask

    task automatic ctl(input logic [W-1:0] d, input logic a, input logic b,
                       input logic p, input logic c, input logic dec);
        data_in = d; lda = a; ldb = b; ldp = p; clrp = c; decb = dec;
        tick();
    endtask

    task automatic s_cyc(input logic [3:0] d, input logic a, input logic b,
                         input logic p, input logic c, input logic dec);
        s_data = d; s_lda = a; s_ldb = b; s_ldp = p; s_clrp = c; s_decb = dec;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        m_a = 0; m_b = 0; m_p = 0; m_prod = 0; m_valid = 0; m_ovf = 0; m_done_q = 0;
        rst_n = 1'b0; data_in = '0; lda = 0; ldb = 0; ldp = 0; clrp = 0; decb = 0;
        done = 0; result_ready = 0;
        s_rst_n = 1'b0; s_data = '0; s_lda = 0; s_ldb = 0; s_ldp = 0; s_clrp = 0;
        s_decb = 0; s_done = 0; s_ready = 0;

        // reset state
        tick(); tick();
        chk("rst_product", product, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_zf", zf, 1);
        rst_n = 1'b1;

        // nominal 7 * 5
        ctl(16'd7, 1, 0, 0, 0, 0);
        ctl(16'd5, 0, 1, 0, 0, 0);
        ctl(16'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) ctl(16'd0, 0, 0, 1, 0, 1);
        chk("nom_zf_before_last", zf, 0);
        ctl(16'd0, 0, 0, 1, 0, 1);
        chk("nom_p", dut.p_q, 35);
        chk("nom_model_p", m_p, 35);
        chk("nom_zf", zf, 1);
        done = 1; ctl(16'd0, 0, 0, 0, 0, 0);
        chk("nom_product", product, 35);
        chk("nom_valid", result_valid, 1);
        result_ready = 1; ctl(16'd0, 0, 0, 0, 0, 0);
        chk("nom_accept", result_valid, 0);
        done = 0; result_ready = 0; ctl(16'd0, 0, 0, 0, 0, 0);

        // zero multiplier
        ctl(16'd9, 1, 0, 0, 0, 0);
        ctl(16'd0, 0, 1, 0, 0, 0);
        ctl(16'd0, 0, 0, 0, 1, 0);
        ctl(16'd0, 0, 0, 1, 0, 1);
        chk("zero_p", dut.p_q, 0);
        chk("zero_b", dut.b_q, 0);
        chk("zero_zf", zf, 1);
        done = 1; ctl(16'd0, 0, 0, 0, 0, 0);
        chk("zero_product", product, 0);
        chk("zero_valid", result_valid, 1);
        done = 0; result_ready = 1; ctl(16'd0, 0, 0, 0, 0, 0);
        result_ready = 0;

        // priorities
        ctl(16'd12, 1, 0, 0, 0, 0);
        ctl(16'd1, 0, 1, 0, 1, 0);
        ctl(16'd0, 0, 0, 1, 0, 0);
        chk("prio_p12", dut.p_q, 12);
        ctl(16'd0, 0, 0, 1, 1, 0);
        chk("prio_clrp", dut.p_q, 0);
        ctl(16'd9, 0, 1, 0, 0, 0);
        ctl(16'd4, 0, 1, 0, 0, 1);
        chk("prio_ldb", dut.b_q, 4);
        ctl(16'd3, 1, 1, 0, 0, 0);
        chk("prio_both_a", dut.a_q, 3);
        chk("prio_both_b", dut.b_q, 3);

        // handshake: done held high, consumer stalled
        ctl(16'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) ctl(16'd0, 0, 0, 1, 0, 1);
        done = 1;
        for (int i = 0; i < 10; i++) ctl(16'd0, 0, 0, 0, 0, 0);
        chk("hs_product9", product, 9);
        chk("hs_valid", result_valid, 1);
        ctl(16'd10, 1, 0, 0, 0, 0);
        ctl(16'd2, 0, 1, 0, 0, 0);
        ctl(16'd0, 0, 0, 0, 1, 0);
        ctl(16'd0, 0, 0, 1, 0, 1);
        ctl(16'd0, 0, 0, 1, 0, 1);
        chk("hs_p20", dut.p_q, 20);
        chk("hs_no_recapture", product, 9);
        done = 0; ctl(16'd0, 0, 0, 0, 0, 0);
        done = 1; ctl(16'd0, 0, 0, 0, 0, 0);
        chk("hs_overwrite", product, 20);
        chk("hs_valid2", result_valid, 1);
        done = 0; result_ready = 1; ctl(16'd0, 0, 0, 0, 0, 0);
        chk("hs_accept", result_valid, 0);
        result_ready = 0;

        // reset mid-run after 2 of 5 accumulates
        ctl(16'd7, 1, 0, 0, 0, 0);
        ctl(16'd5, 0, 1, 0, 0, 0);
        ctl(16'd0, 0, 0, 0, 1, 0);
        ctl(16'd0, 0, 0, 1, 0, 1);
        ctl(16'd0, 0, 0, 1, 0, 1);
        chk("mid_p14", dut.p_q, 14);
        rst_n = 0; ctl(16'd0, 0, 0, 1, 0, 1);
        chk("mid_a", dut.a_q, 0);
        chk("mid_b", dut.b_q, 0);
        chk("mid_p", dut.p_q, 0);
        chk("mid_valid", result_valid, 0);
        chk("mid_ovf", ovf, 0);
        rst_n = 1;
        ctl(16'd0, 0, 0, 0, 0, 0);
        ctl(16'd0, 0, 0, 0, 0, 0);
        chk("mid_no_capture", result_valid, 0);

        // overflow on narrow instance: 15 * 3 in 4 bits
        s_cyc(4'd0, 0, 0, 0, 0, 0);
        s_rst_n = 1'b1;
        s_cyc(4'd15, 1, 0, 0, 0, 0);
        s_cyc(4'd3, 0, 1, 0, 0, 0);
        s_cyc(4'd0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) s_cyc(4'd0, 0, 0, 1, 0, 1);
        chk("ovf_zf", s_zf, 1);
        chk("ovf_p", dut_s.p_q, SAT ? 15 : 13);
        chk("ovf_flag", s_ovf, SAT ? 1 : 0);
        s_cyc(4'd0, 0, 0, 0, 1, 0);
        chk("ovf_clr_p", dut_s.p_q, 0);
        chk("ovf_clr_flag", s_ovf, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
